// File: rtl/sprite_pkg.sv
// Shared constants, attribute layout, FSM state encoding and helpers for the
// scanline sprite engine.
package sprite_pkg;

  localparam int unsigned NUM_SPRITES = 16;
  localparam int unsigned SPR_SIZE    = 16;
  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned V_LAST      = 524;

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned ATTR_W  = 32;
  localparam int unsigned LINE_W  = 10;
  localparam int unsigned ROM_AW  = 14;
  localparam int unsigned PIX_W   = 16;
  localparam int unsigned DRAW_AW = 10;
  localparam int unsigned SUM_W   = 11;

  localparam int unsigned ATTR_X_LSB     = 0;
  localparam int unsigned ATTR_X_W       = 10;
  localparam int unsigned ATTR_Y_LSB     = 10;
  localparam int unsigned ATTR_Y_W       = 9;
  localparam int unsigned ATTR_FRAME_LSB = 19;
  localparam int unsigned ATTR_FRAME_W   = 6;
  localparam int unsigned ATTR_FLIP_BIT  = 25;
  localparam int unsigned ATTR_RSVD_LSB  = 26;
  localparam int unsigned ATTR_RSVD_W    = 5;
  localparam int unsigned ATTR_EN_BIT    = 31;

  localparam int unsigned PIX_TRANSP_BIT = 15;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic                    en;
    logic [ATTR_RSVD_W-1:0]  rsvd;
    logic                    flip_h;
    logic [ATTR_FRAME_W-1:0] frame;
    logic [ATTR_Y_W-1:0]     y;
    logic [ATTR_X_W-1:0]     x;
  } sprite_attr_t;

  // Unpack a CPU attribute word into its fields.
  function automatic sprite_attr_t attr_from_word(input logic [ATTR_W-1:0] w);
    sprite_attr_t a;
    a.en     = w[ATTR_EN_BIT];
    a.rsvd   = w[ATTR_RSVD_LSB +: ATTR_RSVD_W];
    a.flip_h = w[ATTR_FLIP_BIT];
    a.frame  = w[ATTR_FRAME_LSB +: ATTR_FRAME_W];
    a.y      = w[ATTR_Y_LSB +: ATTR_Y_W];
    a.x      = w[ATTR_X_LSB +: ATTR_X_W];
    return a;
  endfunction

endpackage

// File: rtl/sprite_attr_table.sv
// Sprite attribute register file: one synchronous write port, one
// combinational read port, all entries cleared (disabled) on reset.
module sprite_attr_table
  import sprite_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [ATTR_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output sprite_attr_t      rdata_c
);

  sprite_attr_t mem [ENTRIES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < ENTRIES; k++) begin
        mem[k] <= '0;
      end
    end else if (we && (32'(waddr) < ENTRIES)) begin
      mem[waddr] <= attr_from_word(wdata);
    end
  end

  assign rdata_c = (32'(raddr) < ENTRIES) ? mem[raddr] : '0;

endmodule

// File: rtl/sprite_engine.sv
// Scanline sprite renderer: scans the attribute table for sprites covering
// the next line and streams their opaque pixels into the linebuffer.
module sprite_engine #(
  parameter int unsigned NUM_SPRITES = sprite_pkg::NUM_SPRITES,
  parameter int unsigned SPR_SIZE    = sprite_pkg::SPR_SIZE
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          attr_we,
  input  logic [sprite_pkg::IDX_W-1:0]  attr_addr,
  input  logic [sprite_pkg::ATTR_W-1:0] attr_wdata,
  input  logic                          sprite_start,
  input  logic [sprite_pkg::LINE_W-1:0] vcount,
  output logic                          sprite_done,
  output logic [sprite_pkg::ROM_AW-1:0] rom_addr,
  input  logic [sprite_pkg::PIX_W-1:0]  rom_q,
  output logic [sprite_pkg::DRAW_AW-1:0] addr_pixel_draw,
  output logic [sprite_pkg::PIX_W-1:0]  data_pixel_draw,
  output logic                          wren_pixel_draw
);

  import sprite_pkg::*;

  localparam int unsigned CNT_W = $clog2(SPR_SIZE) + 1;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [LINE_W-1:0]       line;
  logic [ATTR_X_W-1:0]     cur_x;
  logic [ATTR_FRAME_W-1:0] cur_frame;
  logic                    cur_flip;
  logic [3:0]              row;
  logic [CNT_W-1:0]        col_cnt;
  logic                    pend_valid;
  logic [SUM_W-1:0]        pend_col;

  sprite_attr_t      entry_c;
  logic [SUM_W-1:0]  dy_c;
  logic              hit_c;
  logic              last_c;
  logic [LINE_W-1:0] next_line_c;
  logic [3:0]        col_c;
  logic [3:0]        first_col_c;
  logic              unused_rsvd;

  sprite_attr_table #(
    .ENTRIES (NUM_SPRITES)
  ) u_table (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (attr_we),
    .waddr   (attr_addr),
    .wdata   (attr_wdata),
    .raddr   (idx),
    .rdata_c (entry_c)
  );

  assign unused_rsvd = ^entry_c.rsvd;

  // Hit test uses an 11-bit difference so a sprite below the line borrows
  // into the sign bit instead of wrapping into range.
  always_comb begin
    next_line_c = (vcount >= LINE_W'(V_LAST)) ? '0 : vcount + LINE_W'(1);
    dy_c        = SUM_W'(line) - SUM_W'(entry_c.y);
    hit_c       = entry_c.en && !dy_c[SUM_W-1] && (dy_c < SUM_W'(SPR_SIZE));
    last_c      = (idx == IDX_W'(NUM_SPRITES - 1));
    first_col_c = entry_c.flip_h ? 4'(SPR_SIZE - 1) : 4'd0;
    col_c       = 4'(col_cnt);
    if (cur_flip) begin
      col_c = 4'(SPR_SIZE - 1) - 4'(col_cnt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      idx             <= '0;
      line            <= '0;
      cur_x           <= '0;
      cur_frame       <= '0;
      cur_flip        <= 1'b0;
      row             <= '0;
      col_cnt         <= '0;
      pend_valid      <= 1'b0;
      pend_col        <= '0;
      sprite_done     <= 1'b0;
      rom_addr        <= '0;
      wren_pixel_draw <= 1'b0;
      addr_pixel_draw <= '0;
      data_pixel_draw <= '0;
    end else begin
      // Write stage: ROM data for the previous read lands in the linebuffer.
      wren_pixel_draw <= 1'b0;
      if (pend_valid && !sprite_start) begin
        wren_pixel_draw <= !rom_q[PIX_TRANSP_BIT] && (pend_col < SUM_W'(H_ACTIVE));
        addr_pixel_draw <= pend_col[DRAW_AW-1:0];
        data_pixel_draw <= rom_q;
      end

      if (sprite_start) begin
        state       <= SCAN;
        idx         <= '0;
        line        <= next_line_c;
        sprite_done <= 1'b0;
        pend_valid  <= 1'b0;
      end else begin
        case (state)
          SCAN: begin
            cur_x     <= entry_c.x;
            cur_frame <= entry_c.frame;
            cur_flip  <= entry_c.flip_h;
            if (hit_c) begin
              state      <= FETCH;
              row        <= dy_c[3:0];
              rom_addr   <= {entry_c.frame, dy_c[3:0], first_col_c};
              pend_valid <= 1'b1;
              pend_col   <= SUM_W'(entry_c.x);
              col_cnt    <= CNT_W'(1);
            end else if (last_c) begin
              state       <= DONE;
              sprite_done <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          FETCH: begin
            if (col_cnt == CNT_W'(SPR_SIZE)) begin
              state      <= DRAIN;
              pend_valid <= 1'b0;
            end else begin
              rom_addr <= {cur_frame, row, col_c};
              pend_col <= SUM_W'(cur_x) + SUM_W'(col_cnt);
              col_cnt  <= col_cnt + CNT_W'(1);
            end
          end
          DRAIN: begin
            if (last_c) begin
              state       <= DONE;
              sprite_done <= 1'b1;
            end else begin
              state <= SCAN;
              idx   <= idx + IDX_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Scoreboard bench for sprite_engine: directed lines push expected linebuffer
// writes; a negedge monitor pops and compares every write the DUT makes.
module tb_sprite_engine;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        attr_we;
  logic [3:0]  attr_addr;
  logic [31:0] attr_wdata;
  logic        sprite_start;
  logic [9:0]  vcount;
  logic        sprite_done;
  logic [13:0] rom_addr;
  logic [15:0] rom_q;
  logic [9:0]  addr_pixel_draw;
  logic [15:0] data_pixel_draw;
  logic        wren_pixel_draw;

  logic [1:0]  rom_sel;
  logic [25:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;

  sprite_engine #(.NUM_SPRITES(16), .SPR_SIZE(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .attr_we         (attr_we),
    .attr_addr       (attr_addr),
    .attr_wdata      (attr_wdata),
    .sprite_start    (sprite_start),
    .vcount          (vcount),
    .sprite_done     (sprite_done),
    .rom_addr        (rom_addr),
    .rom_q           (rom_q),
    .addr_pixel_draw (addr_pixel_draw),
    .data_pixel_draw (data_pixel_draw),
    .wren_pixel_draw (wren_pixel_draw)
  );

  always #5 clk = ~clk;

  // Pixel ROM: 0 = solid red, 1 = pixel value equals its column,
  // 2 = frame 1 solid blue, other frames green on even columns, clear on odd.
  always_comb begin
    case (rom_sel)
      2'd0:    rom_q = 16'h7C00;
      2'd1:    rom_q = {12'h000, rom_addr[3:0]};
      default: rom_q = (rom_addr[13:8] == 6'd1) ? 16'h001F :
                       (rom_addr[0] ? 16'h8000 : 16'h03E0);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [25:0] e;
    if (reset_n && wren_pixel_draw) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h expected no write",
                 addr_pixel_draw, data_pixel_draw);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(addr_pixel_draw), 32'(e[25:16]));
        chk("write_data", 32'(data_pixel_draw), 32'(e[15:0]));
      end
    end
  end

  function automatic logic [31:0] mk(input int x, input int y, input int frame,
                                     input int flip, input int en);
    return {1'(en), 5'b0, 1'(flip), 6'(frame), 9'(y), 10'(x)};
  endfunction

  task automatic wr_attr(input int idx, input logic [31:0] word);
    @(negedge clk);
    attr_we    = 1'b1;
    attr_addr  = 4'(idx);
    attr_wdata = word;
    @(negedge clk);
    attr_we    = 1'b0;
  endtask

  task automatic clear_table();
    for (int k = 0; k < 16; k++) wr_attr(k, 32'h0);
  endtask

  task automatic push_run(input int x0, input int n, input logic [15:0] d);
    for (int k = 0; k < n; k++) exp_q.push_back({10'(x0 + k), d});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    sprite_start = 1'b1;
    @(negedge clk);
    sprite_start = 1'b0;
  endtask

  // Start a line and check done latency (cycles from the start edge).
  task automatic run_line(input string name, input logic [9:0] vc, input int exp_lat);
    int cnt;
    vcount = vc;
    pulse_start();
    cnt = 0;
    while (!sprite_done && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    chk({name, "_latency"}, 32'(cnt), 32'(exp_lat));
    @(negedge clk);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    attr_we      = 1'b0;
    attr_addr    = '0;
    attr_wdata   = '0;
    sprite_start = 1'b0;
    vcount       = '0;
    rom_sel      = 2'd0;
    #12;
    chk("rst_done", 32'(sprite_done), 32'd0);
    chk("rst_wren", 32'(wren_pixel_draw), 32'd0);
    chk("rst_addr", 32'(addr_pixel_draw), 32'd0);
    chk("rst_data", 32'(data_pixel_draw), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_line("blank", 10'd100, 16);

    wr_attr(0, mk(100, 50, 2, 0, 1));
    push_run(100, 16, 16'h7C00);
    run_line("basic", 10'd49, 33);
    chk("basic_rom_addr", 32'(rom_addr), 32'h20F);
    clear_table();

    wr_attr(3, mk(630, 50, 1, 0, 1));
    push_run(630, 10, 16'h7C00);
    run_line("right_edge", 10'd49, 33);
    clear_table();

    rom_sel = 2'd1;
    wr_attr(5, mk(200, 100, 0, 1, 1));
    for (int k = 0; k < 16; k++) exp_q.push_back({10'(200 + k), 16'(15 - k)});
    run_line("flip", 10'd103, 33);
    chk("flip_rom_addr", 32'(rom_addr), 32'h040);
    clear_table();

    rom_sel = 2'd2;
    wr_attr(1, mk(300, 10, 1, 0, 1));
    wr_attr(2, mk(300, 10, 2, 0, 1));
    push_run(300, 16, 16'h001F);
    for (int k = 0; k < 16; k += 2) exp_q.push_back({10'(300 + k), 16'h03E0});
    run_line("overlap", 10'd9, 50);
    clear_table();

    rom_sel = 2'd0;
    wr_attr(7, mk(0, 0, 3, 0, 1));
    push_run(0, 16, 16'h7C00);
    run_line("wrap", 10'd524, 33);
    chk("wrap_rom_addr", 32'(rom_addr), 32'h30F);
    clear_table();

    // Restart mid-render: four pixels of entry 0 land, then a full redraw.
    wr_attr(0, mk(100, 50, 2, 0, 1));
    wr_attr(4, mk(400, 50, 2, 0, 1));
    push_run(100, 4, 16'h7C00);
    push_run(100, 16, 16'h7C00);
    push_run(400, 16, 16'h7C00);
    vcount = 10'd49;
    pulse_start();
    repeat (4) @(negedge clk);
    run_line("restart", 10'd49, 50);
    clear_table();

    // Reset mid-fetch after three pixels.
    wr_attr(0, mk(100, 50, 2, 0, 1));
    push_run(100, 3, 16'h7C00);
    vcount = 10'd49;
    pulse_start();
    repeat (4) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_wren", 32'(wren_pixel_draw), 32'd0);
    chk("midrst_addr", 32'(addr_pixel_draw), 32'd0);
    chk("midrst_data", 32'(data_pixel_draw), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    chk("midrst_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_resume_done", 32'(sprite_done), 32'd0);
    run_line("post_reset", 10'd49, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
